// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage and the data memory LSU.
interface dmem_lsu_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_fault;

  // Pipeline side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lsu.sv
// RV32 byte-addressed data memory with load/store formatting, fault detection
// and an optional post-reset zeroing sweep.
module dmem_lsu #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus,
  output logic       init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned BAW   = ADDR_WIDTH + 2;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;
  logic                  init_done_q;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           mem_rdata_q;

  logic                  rsp_valid_q;
  logic                  rsp_fault_q;
  logic                  ld_ok_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic                  fault;
  logic [3:0]            be;
  logic [31:0]           lane;
  logic [3:0]            wr_be;
  logic                  ld_go;
  logic                  clear_we;
  logic [31:0]           shifted;
  logic [31:0]           rdata;

  assign accept   = bus.req_valid & ready_q;
  assign idx      = bus.req_addr[BAW-1:2];
  assign off      = bus.req_addr[1:0];
  assign clear_we = (state_q == S_CLEAR);

  // Decode width, alignment fault and byte-lane enables for the request.
  always_comb begin
    fault = 1'b0;
    be    = 4'b0000;
    lane  = 32'h0;
    if (bus.req_we) begin
      unique case (bus.req_funct3)
        F3_B: begin
          be   = 4'b0001 << off;
          lane = {4{bus.req_wdata[7:0]}};
        end
        F3_H: begin
          fault = off[0];
          be    = 4'b0011 << off;
          lane  = {2{bus.req_wdata[15:0]}};
        end
        F3_W: begin
          fault = (off != 2'b00);
          be    = 4'b1111;
          lane  = bus.req_wdata;
        end
        default: fault = 1'b1;
      endcase
    end else begin
      unique case (bus.req_funct3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = off[0];
        F3_W:        fault = (off != 2'b00);
        default:     fault = 1'b1;
      endcase
    end
  end

  assign wr_be = (accept && bus.req_we && !fault) ? be : 4'b0000;
  assign ld_go = accept & ~bus.req_we & ~fault;

  // Single-port array: clear sweep or byte-lane store, plus load read.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_q] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= lane[8*b +: 8];
      end
    end
    if (ld_go) mem_rdata_q <= mem[idx];
  end

  // Control FSM: zeroing sweep after reset, then permanently idle/ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          ready_q     <= 1'b1;
          init_done_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Response pipeline stage: one-cycle pulse with load format context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      ld_ok_q     <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      rsp_valid_q <= accept;
      rsp_fault_q <= accept & fault;
      ld_ok_q     <= ld_go;
      if (accept) begin
        f3_q  <= bus.req_funct3;
        off_q <= off;
      end
    end
  end

  // Load formatting: align the selected bytes to bit 0 and extend.
  always_comb begin
    shifted = mem_rdata_q >> {off_q, 3'b000};
    rdata   = 32'h0;
    if (ld_ok_q) begin
      unique case (f3_q)
        F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
        F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
        F3_BU:   rdata = {24'h0, shifted[7:0]};
        F3_HU:   rdata = {16'h0, shifted[15:0]};
        default: rdata = mem_rdata_q;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rdata;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a 16-word array and clear-on-reset enabled.
module tb_dmem_lsu;

  localparam int unsigned AW  = 4;
  localparam int unsigned BAW = AW + 2;

  logic clk;
  logic rst_n;
  logic init_done;
  int   checks;
  int   errors;

  dmem_lsu_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_lsu #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request, held for one edge; returns what the response cycle shows.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic v, output logic [31:0] rd,
                       output logic flt);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = BAW'(addr);
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    v   = bus.rsp_valid;
    rd  = bus.rsp_rdata;
    flt = bus.rsp_fault;
  endtask

  task automatic test_reset();
    int cycles;
    int early;
    logic v, flt;
    logic [31:0] rd;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_fault, init_done, bus.rsp_rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b valid=%b fault=%b init=%b rdata=%h exp all 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_fault, init_done, bus.rsp_rdata);
    end
    #10;
    rst_n = 1'b1;
    cycles = 0;
    early  = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.rsp_valid !== 1'b0) early++;
      if (bus.req_ready === 1'b1) break;
    end
    checks++;
    if (cycles !== 16) begin
      errors++;
      $display("FAIL sweep_len cycles=%0d exp 16", cycles);
    end
    checks++;
    if (init_done !== 1'b1 || early !== 0) begin
      errors++;
      $display("FAIL sweep_done init=%b stray_valid=%0d exp 1/0", init_done, early);
    end
    issue(1'b0, 3'd2, 32'h08, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL lw_cleared_08 v=%b rd=%h f=%b exp 1/00000000/0", v, rd, flt);
    end
    issue(1'b0, 3'd2, 32'h3C, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL lw_cleared_3c v=%b rd=%h f=%b exp 1/00000000/0", v, rd, flt);
    end
  endtask

  task automatic test_load_ext();
    logic v, flt;
    logic [31:0] rd;
    issue(1'b1, 3'd2, 32'h100, 32'h8000_7F80, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL sw_rsp v=%b rd=%h f=%b exp 1/00000000/0", v, rd, flt);
    end
    issue(1'b0, 3'd0, 32'h100, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'hFFFF_FF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_100 v=%b rd=%h f=%b exp 1/ffffff80/0", v, rd, flt);
    end
    issue(1'b0, 3'd4, 32'h101, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0000_007F, 1'b0}) begin
      errors++;
      $display("FAIL lbu_101 v=%b rd=%h f=%b exp 1/0000007f/0", v, rd, flt);
    end
    issue(1'b0, 3'd1, 32'h102, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'hFFFF_8000, 1'b0}) begin
      errors++;
      $display("FAIL lh_102 v=%b rd=%h f=%b exp 1/ffff8000/0", v, rd, flt);
    end
    issue(1'b0, 3'd5, 32'h102, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0000_8000, 1'b0}) begin
      errors++;
      $display("FAIL lhu_102 v=%b rd=%h f=%b exp 1/00008000/0", v, rd, flt);
    end
    issue(1'b0, 3'd0, 32'h103, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'hFFFF_FF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_103 v=%b rd=%h f=%b exp 1/ffffff80/0", v, rd, flt);
    end
  endtask

  task automatic test_store_lanes();
    logic v, flt;
    logic [31:0] rd;
    issue(1'b1, 3'd2, 32'h40, 32'h1122_3344, v, rd, flt);
    issue(1'b1, 3'd0, 32'h42, 32'h1234_56AB, v, rd, flt);
    issue(1'b0, 3'd2, 32'h40, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h11AB_3344, 1'b0}) begin
      errors++;
      $display("FAIL sb_42 v=%b rd=%h f=%b exp 1/11ab3344/0", v, rd, flt);
    end
    issue(1'b1, 3'd1, 32'h40, 32'hCAFE_BEEF, v, rd, flt);
    issue(1'b0, 3'd2, 32'h40, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h11AB_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL sh_40 v=%b rd=%h f=%b exp 1/11abbeef/0", v, rd, flt);
    end
  endtask

  task automatic test_faults();
    logic v, flt;
    logic [31:0] rd;
    issue(1'b0, 3'd2, 32'h41, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL lw_41_fault v=%b rd=%h f=%b exp 1/00000000/1", v, rd, flt);
    end
    issue(1'b1, 3'd1, 32'h43, 32'h0000_FFFF, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL sh_43_fault v=%b rd=%h f=%b exp 1/00000000/1", v, rd, flt);
    end
    issue(1'b0, 3'd3, 32'h40, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL ld_f3_3_fault v=%b rd=%h f=%b exp 1/00000000/1", v, rd, flt);
    end
    issue(1'b1, 3'd4, 32'h40, 32'hFFFF_FFFF, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL st_f3_4_fault v=%b rd=%h f=%b exp 1/00000000/1", v, rd, flt);
    end
    issue(1'b1, 3'd2, 32'h42, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL sw_42_fault v=%b rd=%h f=%b exp 1/00000000/1", v, rd, flt);
    end
    issue(1'b0, 3'd2, 32'h40, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h11AB_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL word_40_kept v=%b rd=%h f=%b exp 1/11abbeef/0", v, rd, flt);
    end
  endtask

  task automatic test_back_to_back();
    logic v1, v2, v3;
    logic [31:0] rd1, rd2, rd3;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = BAW'(32'h20);
    bus.req_wdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    v1  = bus.rsp_valid;
    rd1 = bus.rsp_rdata;
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'h0;
    @(posedge clk);
    #1;
    v2  = bus.rsp_valid;
    rd2 = bus.rsp_rdata;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    v3  = bus.rsp_valid;
    rd3 = bus.rsp_rdata;
    checks++;
    if ({v1, rd1} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL b2b_store_rsp v=%b rd=%h exp 1/00000000", v1, rd1);
    end
    checks++;
    if ({v2, rd2} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL b2b_load_rsp v=%b rd=%h exp 1/deadbeef", v2, rd2);
    end
    checks++;
    if ({v3, rd3, bus.rsp_fault} !== {1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_idle_rsp v=%b rd=%h f=%b exp 0/00000000/0", v3, rd3, bus.rsp_fault);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    logic v, flt;
    logic [31:0] rd;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = BAW'(32'h20);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready, init_done} !== 35'h0) begin
      errors++;
      $display("FAIL midrst_drop v=%b rd=%h ready=%b init=%b exp all 0",
               bus.rsp_valid, bus.rsp_rdata, bus.req_ready, init_done);
    end
    #20;
    rst_n = 1'b1;
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (init_done === 1'b1) break;
    end
    checks++;
    if (cycles !== 16 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_sweep cycles=%0d ready=%b exp 16/1", cycles, bus.req_ready);
    end
    issue(1'b0, 3'd2, 32'h20, 32'h0, v, rd, flt);
    checks++;
    if ({v, rd, flt} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_cleared v=%b rd=%h f=%b exp 1/00000000/0", v, rd, flt);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
